// File: rtl/spi_byte_master_pkg.sv
// Shared types and constants for the SPI byte engine and the flash command sequencer above it.
package spi_byte_master_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DIV_W     = 8;   // holds CLK_DIV-1 for CLK_DIV up to 255
  localparam int unsigned EDGE_W    = 4;
  localparam int unsigned NUM_EDGES = 16;  // two dclk edges per bit

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_SETUP  = 3'd1,
    ST_CS_ACTIVE = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_CS_HOLD   = 3'd5,
    ST_CS_GAP    = 3'd6
  } state_e;

  // M25P16 opcodes issued by the sequencer
  localparam logic [BYTE_W-1:0] OP_WREN = 8'h06;
  localparam logic [BYTE_W-1:0] OP_RDSR = 8'h05;
  localparam logic [BYTE_W-1:0] OP_READ = 8'h03;
  localparam logic [BYTE_W-1:0] OP_PP   = 8'h02;
  localparam logic [BYTE_W-1:0] OP_SE   = 8'hD8;
  localparam logic [BYTE_W-1:0] OP_RDID = 8'h9F;

  // States in which the half-period divider runs
  function automatic logic is_timed(state_e s);
    return (s == ST_CS_SETUP) || (s == ST_SHIFT) || (s == ST_CS_HOLD) || (s == ST_CS_GAP);
  endfunction

endpackage

// File: rtl/spi_byte_master_clk_gen.sv
// Half-period divider, dclk toggle and edge counter for one byte; emits edge strobes.
module spi_byte_master_clk_gen
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter logic        CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic timed_i,
  input  logic run_i,
  output logic tick_c,
  output logic lead_edge_c,
  output logic trail_edge_c,
  output logic done_c,
  output logic dclk_o
);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(NUM_EDGES - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              dclk_q, dclk_d;
  logic              edge_c;

  // Terminal count and edge strobes; even edge index is leading, odd is trailing
  always_comb begin
    tick_c       = timed_i && (div_q == DIV_LAST);
    edge_c       = run_i && tick_c;
    lead_edge_c  = edge_c && !edge_q[0];
    trail_edge_c = edge_c && edge_q[0];
    done_c       = edge_c && (edge_q == EDGE_LAST);
  end

  // Next values: divider restarts on state entry and on every terminal count
  always_comb begin
    div_d  = div_q;
    edge_d = edge_q;
    dclk_d = dclk_q;
    if (clear_i || !timed_i || tick_c) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (!run_i) begin
      edge_d = '0;
      dclk_d = CPOL;
    end else if (edge_c) begin
      edge_d = edge_q + EDGE_W'(1);
      dclk_d = ~dclk_q;
    end
  end

  // Divider, edge counter and dclk registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      edge_q <= '0;
      dclk_q <= CPOL;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      dclk_q <= dclk_d;
    end
  end

  assign dclk_o = dclk_q;

endmodule

// File: rtl/spi_byte_master.sv
// Byte-level SPI master: chip-select framing from the sequencer, MSB-first byte shifting.
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter logic        CPOL    = 1'b0,
  parameter logic        CPHA    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_req,
  input  logic       wr_req,
  input  logic [7:0] data_in,
  output logic       wr_ack,
  output logic [7:0] data_out,
  output logic       ncs,
  output logic       dclk,
  output logic       mosi,
  input  logic       miso
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] rx_q, rx_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              mosi_q, mosi_d;
  logic              ncs_q, ncs_d;
  logic              wr_ack_q, wr_ack_d;

  logic tick_c, lead_edge_c, trail_edge_c, done_c;
  logic sample_c, shift_c;

  spi_byte_master_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (state_d != state_q),
    .timed_i      (is_timed(state_q)),
    .run_i        (state_q == ST_SHIFT),
    .tick_c       (tick_c),
    .lead_edge_c  (lead_edge_c),
    .trail_edge_c (trail_edge_c),
    .done_c       (done_c),
    .dclk_o       (dclk)
  );

  // CPHA picks which dclk edge samples miso and which one moves mosi
  always_comb begin
    sample_c = CPHA ? trail_edge_c : lead_edge_c;
    shift_c  = CPHA ? lead_edge_c  : trail_edge_c;
  end

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mosi_d     = mosi_q;
    data_out_d = data_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_req) state_d = ST_CS_SETUP;
      end
      ST_CS_SETUP: begin
        if (tick_c) state_d = ST_CS_ACTIVE;
      end
      ST_CS_ACTIVE: begin
        // Dropping cs_req wins over a pending byte request
        if (!cs_req) begin
          state_d = ST_CS_HOLD;
        end else if (wr_req) begin
          state_d = ST_SHIFT;
          tx_d    = data_in;
          rx_d    = '0;
          if (!CPHA) mosi_d = data_in[7];
        end
      end
      ST_SHIFT: begin
        if (sample_c) rx_d = {rx_q[BYTE_W-2:0], miso};
        // With CPHA=0 the last trailing edge has no bit left to present
        if (shift_c && (CPHA || !done_c)) begin
          mosi_d = CPHA ? tx_q[BYTE_W-1] : tx_q[BYTE_W-2];
          tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
        end
        if (done_c) begin
          state_d    = ST_ACK;
          data_out_d = rx_d;
        end
      end
      ST_ACK: begin
        state_d = ST_CS_ACTIVE;
      end
      ST_CS_HOLD: begin
        if (tick_c) state_d = ST_CS_GAP;
      end
      ST_CS_GAP: begin
        if (tick_c) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ncs_d    = (state_d == ST_IDLE) || (state_d == ST_CS_GAP);
    wr_ack_d = (state_d == ST_ACK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      mosi_q     <= 1'b0;
      ncs_q      <= 1'b1;
      wr_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      mosi_q     <= mosi_d;
      ncs_q      <= ncs_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  assign wr_ack   = wr_ack_q;
  assign data_out = data_out_q;
  assign ncs      = ncs_q;
  assign mosi     = mosi_q;

endmodule
